// File: rtl/midi_pkg.sv
// -----------------------------------------------------------------------------
// midi_pkg
// Shared definitions for the MIDI receiver array: lane FSM state encoding,
// frame geometry and a helper for sizing channel-index fields.
// No ports (package).
// -----------------------------------------------------------------------------
package midi_pkg;

    // Data bits per MIDI frame (8N1).
    localparam int MIDI_BITS = 8;

    // Lane receiver states. Explicit encoding keeps the state register
    // readable in waveforms and stable across tool versions.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } midi_rx_state_t;

    // Width of a channel index; never narrower than one bit so a
    // single-lane build still has a legal rx_ch port.
    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/midi_rx_lane.sv
// -----------------------------------------------------------------------------
// midi_rx_lane
// One MIDI UART receive lane: input synchroniser, start/data/stop/break FSM
// with false-start rejection, a one-byte holding register and a sticky
// overrun flag.
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   i_line       in   raw serial line, idle high, asynchronous to clk
//   i_en         in   lane enable; low forces IDLE and aborts a frame
//   i_take       in   arbiter is consuming the holding register this cycle
//   i_ovr_clr    in   write-1-to-clear for o_ovr
//   o_hold_v     out  holding register contains an unread byte
//   o_hold_data  out  held byte
//   o_hold_err   out  held byte had a framing error (stop bit sampled 0)
//   o_ovr        out  sticky overrun flag
// -----------------------------------------------------------------------------
module midi_rx_lane
    import midi_pkg::*;
#(
    parameter int OVERSAMPLE  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_line,
    input  logic                 i_en,
    input  logic                 i_take,
    input  logic                 i_ovr_clr,
    output logic                 o_hold_v,
    output logic [MIDI_BITS-1:0] o_hold_data,
    output logic                 o_hold_err,
    output logic                 o_ovr
);

    localparam int             CW      = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]  HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]  FULL_M1 = CW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    midi_rx_state_t         r_state;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_bit;
    logic [MIDI_BITS-1:0]   r_shift;
    logic                   r_hold_v;
    logic [MIDI_BITS-1:0]   r_hold_data;
    logic                   r_hold_err;
    logic                   r_ovr;

    logic w_s;
    logic w_fall;
    logic w_tick;
    logic w_stop_done;

    assign w_s         = r_sync[SYNC_STAGES-1];
    assign w_fall      = r_prev & ~w_s;
    assign w_tick      = (r_cnt == FULL_M1);
    assign w_stop_done = i_en && (r_state == STOP) && w_tick;

    // Synchroniser resets to the idle (high) level so a line that is already
    // low when reset releases is seen as a fresh falling edge.
    // r_prev is forced low while disabled: after re-enable the line must be
    // observed high before a falling edge can start a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_line};
            r_prev <= i_en ? w_s : 1'b0;
        end
    end

    // Frame FSM. START waits half a bit to sample the middle of the start
    // bit; every later sample is a full bit further on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else if (!i_en) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state <= START;
                        r_cnt   <= '0;
                    end
                end
                START: begin
                    if (r_cnt == HALF_M1) begin
                        r_state <= w_s ? IDLE : DATA;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_s, r_shift[MIDI_BITS-1:1]};
                        r_cnt   <= '0;
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_state <= w_s ? IDLE : BREAK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (w_s) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Holding register. A byte that completes while the old one is still
    // waiting (and not being taken this cycle) is dropped in favour of the
    // older byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_v    <= 1'b0;
            r_hold_data <= '0;
            r_hold_err  <= 1'b0;
        end else if (w_stop_done && (!r_hold_v || i_take)) begin
            r_hold_v    <= 1'b1;
            r_hold_data <= r_shift;
            r_hold_err  <= ~w_s;
        end else if (i_take) begin
            r_hold_v <= 1'b0;
        end
    end

    // Sticky overrun; a new overrun event beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr <= 1'b0;
        end else if (w_stop_done && r_hold_v && !i_take) begin
            r_ovr <= 1'b1;
        end else if (i_ovr_clr) begin
            r_ovr <= 1'b0;
        end
    end

    assign o_hold_v    = r_hold_v;
    assign o_hold_data = r_hold_data;
    assign o_hold_err  = r_hold_err;
    assign o_ovr       = r_ovr;

endmodule

// File: rtl/midi_rx_array.sv
// -----------------------------------------------------------------------------
// midi_rx_array
// NUM_CH MIDI receive lanes merged by a round-robin arbiter into a single
// channel-tagged valid/ready byte stream.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   midi_in    in   raw serial lines, idle high
//   ch_en      in   per-lane enable
//   rx_data    out  received byte
//   rx_ch      out  source lane of rx_data
//   rx_err     out  framing error flag for rx_data
//   rx_valid   out  output beat valid
//   rx_ready   in   consumer accepts beat when rx_valid && rx_ready
//   ovr        out  sticky per-lane overrun
//   ovr_clr    in   per-lane write-1-to-clear for ovr
// -----------------------------------------------------------------------------
module midi_rx_array
    import midi_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int OVERSAMPLE  = 8,
    parameter int SYNC_STAGES = 2,
    localparam int CHW        = ch_width(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_CH-1:0]    midi_in,
    input  logic [NUM_CH-1:0]    ch_en,
    output logic [MIDI_BITS-1:0] rx_data,
    output logic [CHW-1:0]       rx_ch,
    output logic                 rx_err,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [NUM_CH-1:0]    ovr,
    input  logic [NUM_CH-1:0]    ovr_clr
);

    logic [NUM_CH-1:0]    w_hold_v;
    logic [MIDI_BITS-1:0] w_hold_data [NUM_CH];
    logic [NUM_CH-1:0]    w_hold_err;
    logic [NUM_CH-1:0]    w_take;
    logic                 w_grant_found;
    logic [CHW-1:0]       w_grant_idx;
    logic                 w_load;

    logic [MIDI_BITS-1:0] r_data;
    logic [CHW-1:0]       r_ch;
    logic                 r_err;
    logic                 r_valid;
    logic [CHW-1:0]       r_rr_ptr;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        midi_rx_lane #(
            .OVERSAMPLE  (OVERSAMPLE),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_lane (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_line      (midi_in[g]),
            .i_en        (ch_en[g]),
            .i_take      (w_take[g]),
            .i_ovr_clr   (ovr_clr[g]),
            .o_hold_v    (w_hold_v[g]),
            .o_hold_data (w_hold_data[g]),
            .o_hold_err  (w_hold_err[g]),
            .o_ovr       (ovr[g])
        );
    end

    // Round-robin search: r_rr_ptr names the lane with highest priority,
    // i.e. the lane after the one granted last.
    always_comb begin
        int idx;
        idx           = 0;
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_CH;
            if (!w_grant_found && w_hold_v[idx[CHW-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = idx[CHW-1:0];
            end
        end
    end

    // The output register can accept a new byte when empty or being drained.
    assign w_load = (!r_valid || rx_ready) && w_grant_found;

    always_comb begin
        w_take = '0;
        if (w_load) begin
            w_take[w_grant_idx] = 1'b1;
        end
    end

    // Output register; contents are frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_ch     <= '0;
            r_err    <= 1'b0;
            r_valid  <= 1'b0;
            r_rr_ptr <= '0;
        end else if (!r_valid || rx_ready) begin
            if (w_grant_found) begin
                r_data   <= w_hold_data[w_grant_idx];
                r_ch     <= w_grant_idx;
                r_err    <= w_hold_err[w_grant_idx];
                r_valid  <= 1'b1;
                r_rr_ptr <= (w_grant_idx == CHW'(NUM_CH - 1)) ? '0 : w_grant_idx + 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_data  = r_data;
    assign rx_ch    = r_ch;
    assign rx_err   = r_err;
    assign rx_valid = r_valid;

endmodule

// File: tb/tb_midi_rx_array.sv
// -----------------------------------------------------------------------------
// tb_midi_rx_array
// Scoreboard bench for midi_rx_array (NUM_CH=4, OVERSAMPLE=8). Expected beats
// are queued as frames are driven; a negedge monitor pops and compares every
// accepted beat and checks that stalled beats hold still.
// -----------------------------------------------------------------------------
module tb_midi_rx_array;

    localparam int NUM_CH = 4;
    localparam int OS     = 8;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ch;
        logic       err;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  midiIn;
    logic [3:0]  chEn;
    logic [7:0]  rxData;
    logic [1:0]  rxCh;
    logic        rxErr;
    logic        rxValid;
    logic        rxReady;
    logic [3:0]  ovr;
    logic [3:0]  ovrClr;

    beat_t expQ[$];
    beat_t monExp;
    beat_t prevBeat;
    logic  prevStall = 1'b0;
    int    checks = 0;
    int    errors = 0;

    midi_rx_array #(
        .NUM_CH      (NUM_CH),
        .OVERSAMPLE  (OS),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .midi_in  (midiIn),
        .ch_en    (chEn),
        .rx_data  (rxData),
        .rx_ch    (rxCh),
        .rx_err   (rxErr),
        .rx_valid (rxValid),
        .rx_ready (rxReady),
        .ovr      (ovr),
        .ovr_clr  (ovrClr)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance n rising edges and settle 1 time unit after the last one.
    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectBeat(input logic [7:0] data, input logic [1:0] ch, input logic err);
        beat_t b;
        b.data = data;
        b.ch   = ch;
        b.err  = err;
        expQ.push_back(b);
    endtask

    // Drive one 8N1 frame on a lane, then one idle bit.
    task automatic applyStimulus(input int lane, input logic [7:0] data,
                                 input logic stopLevel, input int stopBits);
        midiIn[lane] = 1'b0;
        waitCycles(OS);
        for (int i = 0; i < 8; i++) begin
            midiIn[lane] = data[i];
            waitCycles(OS);
        end
        midiIn[lane] = stopLevel;
        waitCycles(OS * stopBits);
        midiIn[lane] = 1'b1;
        waitCycles(OS);
    endtask

    // Wait (bounded) until every expected beat has been delivered.
    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (expQ.size() == 0 && !rxValid) break;
            waitCycles(1);
        end
        checkOutput(name, expQ.size(), 0);
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, ".valid"}, rxValid, 0);
        checkOutput({name, ".data"},  rxData,  0);
        checkOutput({name, ".ch"},    rxCh,    0);
        checkOutput({name, ".err"},   rxErr,   0);
        checkOutput({name, ".ovr"},   ovr,     0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        waitCycles(2);
        rst_n = 1'b1;
        waitCycles(2);
    endtask

    // Monitor: compare each accepted beat with the scoreboard head and
    // require a stalled beat to stay unchanged.
    always @(negedge clk) begin
        if (rst_n && rxValid) begin
            if (prevStall) begin
                checkOutput("stallStable", {rxData, rxCh, rxErr}, prevBeat);
            end
            if (rxReady) begin
                prevStall = 1'b0;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedBeat: got data 0x%0h ch %0d err %0d, none expected",
                             rxData, rxCh, rxErr);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("beat.data", rxData, monExp.data);
                    checkOutput("beat.ch",   rxCh,   monExp.ch);
                    checkOutput("beat.err",  rxErr,  monExp.err);
                end
            end else begin
                prevStall = 1'b1;
                prevBeat  = {rxData, rxCh, rxErr};
            end
        end else begin
            prevStall = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        rst_n   = 1'b0;
        midiIn  = 4'hF;
        chEn    = 4'hF;
        rxReady = 1'b1;
        ovrClr  = 4'h0;
        waitCycles(3);
        checkResetState("reset");
        rst_n = 1'b1;
        waitCycles(4);

        // Normal byte with latency window.
        $display("[TB] normal byte");
        expectBeat(8'h90, 2'd0, 1'b0);
        lat = 0;
        fork
            applyStimulus(0, 8'h90, 1'b1, 1);
            begin
                while (!rxValid && lat < 200) begin
                    waitCycles(1);
                    lat++;
                end
                checkOutput("t1.latencyMin", (lat >= 77), 1);
                checkOutput("t1.latencyMax", (lat <= 80), 1);
            end
        join
        drain("t1.drain", 200);

        // Framing error, stop bit low for one bit.
        $display("[TB] framing error");
        expectBeat(8'h3E, 2'd1, 1'b1);
        applyStimulus(1, 8'h3E, 1'b0, 1);
        waitCycles(12 * OS);
        drain("t2.drain", 200);

        // False start glitch.
        $display("[TB] false start");
        midiIn[2] = 1'b0;
        waitCycles(2);
        midiIn[2] = 1'b1;
        waitCycles(12 * OS);
        drain("t3.drain", 50);

        // Lane disabled mid-frame: nothing is produced.
        $display("[TB] lane disable");
        fork
            applyStimulus(2, 8'h00, 1'b1, 1);
            begin
                waitCycles(3 * OS);
                chEn[2] = 1'b0;
            end
        join
        waitCycles(OS);
        chEn[2] = 1'b1;
        waitCycles(4 * OS);
        drain("t3b.drain", 50);

        // Arbitration from a fresh round-robin pointer.
        $display("[TB] arbitration");
        doReset();
        rxReady = 1'b0;
        expectBeat(8'h3E, 2'd1, 1'b0);
        expectBeat(8'h80, 2'd2, 1'b0);
        fork
            applyStimulus(1, 8'h3E, 1'b1, 1);
            applyStimulus(2, 8'h80, 1'b1, 1);
        join
        checkOutput("t4.stallValid", rxValid, 1);
        checkOutput("t4.stallCh",    rxCh,    1);
        rxReady = 1'b1;
        waitCycles(1);
        checkOutput("t4.b2bValid", rxValid, 1);
        checkOutput("t4.b2bData",  rxData,  8'h80);
        checkOutput("t4.b2bCh",    rxCh,    2);
        waitCycles(1);
        checkOutput("t4.idleAfter", rxValid, 0);
        drain("t4.drain", 50);

        // Overrun: output register blocked by lane 3, then two bytes on lane 0.
        $display("[TB] overrun");
        rxReady = 1'b0;
        expectBeat(8'h55, 2'd3, 1'b0);
        applyStimulus(3, 8'h55, 1'b1, 1);
        expectBeat(8'hF8, 2'd0, 1'b0);
        applyStimulus(0, 8'hF8, 1'b1, 1);
        checkOutput("t5.noOvrYet", ovr, 4'h0);
        applyStimulus(0, 8'hFE, 1'b1, 1);
        checkOutput("t5.ovrSet", ovr, 4'h1);
        ovrClr = 4'h1;
        waitCycles(1);
        ovrClr = 4'h0;
        checkOutput("t5.ovrClr", ovr, 4'h0);
        rxReady = 1'b1;
        drain("t5.drain", 50);

        // Reset during bit 3 of a frame; bits 3..7 are high so the line is
        // idle after release.
        $display("[TB] reset mid-frame");
        fork
            applyStimulus(0, 8'hF8, 1'b1, 1);
            begin
                waitCycles(OS + 3 * OS + OS / 2);
                rst_n = 1'b0;
                waitCycles(1);
                checkResetState("t6.rst");
                waitCycles(1);
                rst_n = 1'b1;
            end
        join
        waitCycles(4 * OS);
        drain("t6.noPartial", 50);

        // Break on lane 3: exactly one error byte, then a clean byte.
        $display("[TB] break");
        expectBeat(8'h00, 2'd3, 1'b1);
        midiIn[3] = 1'b0;
        waitCycles(30 * OS);
        midiIn[3] = 1'b1;
        waitCycles(4 * OS);
        expectBeat(8'h80, 2'd3, 1'b0);
        applyStimulus(3, 8'h80, 1'b1, 1);
        drain("t6.drain", 200);

        checkOutput("final.queueEmpty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
